instruction_fetch_unit: RTL

Fetch stage directly downstream of the program counter. It captures the word address the PC presents and runs a req/ack read handshake against instruction memory. It then holds the returned instruction for the decoder under a valid/ready handshake. It drives halt_temporarily_signal back into the PC, so the PC advances exactly once per instruction the decoder consumes.

---
 rtl/instruction_fetch_unit_pkg.sv | 17 +
 rtl/instruction_fetch_unit_if.sv | 31 +++
 rtl/instruction_fetch_unit_timeout_counter.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage and its PC neighbour.
package instruction_fetch_unit_pkg;

    localparam int WORD_ADDR_W = 32;

    typedef logic [WORD_ADDR_W-1:0] word_t;

    localparam word_t NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of PC, instruction-memory and decoder signals seen by the fetch stage.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    word_t instruction_address;
    logic  halt_temporarily_signal;
    word_t mem_addr;
    logic  mem_req;
    logic  mem_ack;
    word_t mem_rdata;
    word_t instruction;
    word_t fetched_address;
    logic  instruction_valid;
    logic  decode_ready;
    logic  flush;
    logic  fetch_fault;

    // master = the fetch unit itself
    modport master (
        input  instruction_address, mem_ack, mem_rdata, decode_ready, flush,
        output halt_temporarily_signal, mem_addr, mem_req, instruction,
               fetched_address, instruction_valid, fetch_fault
    );

    modport slave (
        output instruction_address, mem_ack, mem_rdata, decode_ready, flush,
        input  halt_temporarily_signal, mem_addr, mem_req, instruction,
               fetched_address, instruction_valid, fetch_fault
    );

endinterface

// File: rtl/instruction_fetch_unit_timeout_counter.sv
// Counts cycles a memory request has waited; expired flags the last allowed cycle.
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // Saturates rather than wrapping so a stuck enable can never re-arm the timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != SAT)
            count <= count + CW'(1);
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: latches the PC address, reads instruction memory, holds the word for decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int    TIMEOUT_CYCLES  = 16,
    parameter word_t NOP_INSTRUCTION = NOP_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    instruction_fetch_unit_if.master bus
);

    fetch_state_t state, next_state;
    logic discard;
    logic cnt_clear, cnt_en, expired;
    logic take_data;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    assign take_data = bus.mem_ack && !discard && !bus.flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                next_state = ST_REQ;
                cnt_clear  = 1'b1;
            end
            ST_REQ: begin
                // Ack beats timeout when both land in the same cycle.
                if (bus.mem_ack)
                    next_state = take_data ? ST_HOLD : ST_IDLE;
                else if (expired)
                    next_state = ST_FAULT;
                else
                    cnt_en = 1'b1;
            end
            ST_HOLD: begin
                if (bus.flush || bus.decode_ready)
                    next_state = ST_IDLE;
            end
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.mem_addr          <= '0;
            bus.mem_req           <= 1'b0;
            bus.instruction       <= NOP_INSTRUCTION;
            bus.fetched_address   <= '0;
            bus.instruction_valid <= 1'b0;
            bus.fetch_fault       <= 1'b0;
            discard               <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.mem_addr <= bus.instruction_address;
                    bus.mem_req  <= 1'b1;
                end
                ST_REQ: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        discard     <= 1'b0;
                        if (take_data) begin
                            bus.instruction       <= bus.mem_rdata;
                            bus.fetched_address   <= bus.mem_addr;
                            bus.instruction_valid <= 1'b1;
                        end
                    end else begin
                        // A flushed request stays on the bus until memory answers it.
                        if (bus.flush)
                            discard <= 1'b1;
                        if (expired) begin
                            bus.mem_req     <= 1'b0;
                            bus.fetch_fault <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.flush) begin
                        bus.instruction_valid <= 1'b0;
                        bus.instruction       <= NOP_INSTRUCTION;
                    end else if (bus.decode_ready) begin
                        bus.instruction_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // PC is released only in the cycle the decoder actually consumes the word.
    assign bus.halt_temporarily_signal =
        !reset && !(state == ST_HOLD && bus.decode_ready && !bus.flush);

endmodule
